// File: rtl/ysyx_wb_arb.sv
// ysyx_wb_arb: NREQ-way writeback arbiter feeding one registered slot.
// Define YSYX_WB_ARB_RR_EN for round-robin grants; otherwise fixed priority (lowest index wins).
`ifndef YSYX_XLEN
`define YSYX_XLEN 64
`endif
module ysyx_wb_arb #(
  parameter int XLEN = `YSYX_XLEN,
  parameter int NREQ = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*5-1:0]    req_rd,
  input  logic [NREQ*XLEN-1:0] req_wdata,
  input  logic [NREQ*32-1:0]   req_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           out_rd,
  output logic [XLEN-1:0]      out_wdata,
  output logic [31:0]          out_pc,
  output logic                 out_wen,
  output logic [1:0]           out_src,
  output logic [31:0]          out_retire_cnt
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam logic [PW:0] NQ = (PW+1)'(NREQ);
  logic [4:0]      rd_a [NREQ];
  logic [XLEN-1:0] wd_a [NREQ];
  logic [31:0]     pc_a [NREQ];
  logic [NREQ-1:0] rot;
  logic [PW-1:0]   off;
  logic [PW-1:0]   win;
  logic            hit;
  logic            slot_free;
  logic            xfer;
  for (genvar i = 0; i < NREQ; i++) begin : g_split
    assign rd_a[i] = req_rd[i*5 +: 5];
    assign wd_a[i] = req_wdata[i*XLEN +: XLEN];
    assign pc_a[i] = req_pc[i*32 +: 32];
  end
  // rot holds the valids rotated so that bit 0 is the current highest-priority requester
  always_comb begin
    off = '0;
    hit = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (rot[k]) begin
        off = PW'(k);
        hit = 1'b1;
      end
  end
`ifdef YSYX_WB_ARB_RR_EN
  logic [PW-1:0]     ptr;
  logic [2*NREQ-1:0] dbl;
  logic [PW:0]       sum;
  assign dbl = {req_valid, req_valid} >> ptr;
  assign rot = dbl[NREQ-1:0];
  assign sum = {1'b0, ptr} + {1'b0, off};
  assign win = sum >= NQ ? PW'(sum - NQ) : sum[PW-1:0];
  always_ff @(posedge clock or negedge reset)
    if (!reset) ptr <= '0;
    else if (xfer) ptr <= {1'b0, win} == NQ - 1'b1 ? '0 : win + 1'b1;
`else
  assign rot = req_valid;
  assign win = off;
`endif
  assign slot_free = !out_valid || out_ready;
  assign xfer      = reset && slot_free && hit;
  assign req_ready = xfer ? {{(NREQ-1){1'b0}}, 1'b1} << win : '0;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      out_valid      <= 1'b0;
      out_rd         <= '0;
      out_wdata      <= '0;
      out_pc         <= '0;
      out_wen        <= 1'b0;
      out_src        <= '0;
      out_retire_cnt <= '0;
    end else begin
      if (out_valid && out_ready) out_retire_cnt <= out_retire_cnt + 32'd1;
      if (xfer) begin
        out_valid <= 1'b1;
        out_rd    <= rd_a[win];
        out_wdata <= wd_a[win];
        out_pc    <= pc_a[win];
        out_wen   <= |rd_a[win];
        out_src   <= 2'(win);
      end else if (out_ready) out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_ysyx_wb_arb.sv
// tb_ysyx_wb_arb: random + directed checks of ysyx_wb_arb against a transaction-level slot model.
module tb_ysyx_wb_arb;
  localparam int XLEN = 64;
  localparam int N = 3;
`ifdef YSYX_WB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*5-1:0]  req_rd;
  logic [N*64-1:0] req_wdata;
  logic [N*32-1:0] req_pc;
  logic            out_valid, out_ready, out_wen;
  logic [4:0]      out_rd;
  logic [63:0]     out_wdata;
  logic [31:0]     out_pc, out_retire_cnt;
  logic [1:0]      out_src;
  int tests = 0, fails = 0;
  bit          m_v, m_wen;
  logic [4:0]  m_rd;
  logic [63:0] m_wd;
  logic [31:0] m_pc, m_cnt;
  int          m_src, m_p;
  logic [31:0] s_cnt;
  logic [4:0]  s_rd;
  logic [63:0] s_wd;
  int          ord [4];
  ysyx_wb_arb #(.XLEN(XLEN), .NREQ(N)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_wdata(req_wdata), .req_pc(req_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_rd(out_rd), .out_wdata(out_wdata), .out_pc(out_pc),
    .out_wen(out_wen), .out_src(out_src), .out_retire_cnt(out_retire_cnt)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_v = 0; m_wen = 0; m_rd = 0; m_wd = 0; m_pc = 0; m_cnt = 0; m_src = 0; m_p = 0;
  endtask
  // winner = first valid requester scanning circularly from the priority pointer; -1 if no grant
  function automatic int model_win();
    if (!reset || (m_v && !out_ready)) return -1;
    for (int j = 0; j < N; j++)
      if (req_valid[(m_p + j) % N]) return (m_p + j) % N;
    return -1;
  endfunction
  task automatic rnd_payload();
    for (int i = 0; i < N; i++) begin
      req_rd[i*5 +: 5]     = 5'($urandom);
      req_wdata[i*64 +: 64] = {$urandom, $urandom};
      req_pc[i*32 +: 32]   = $urandom;
    end
  endtask
  task automatic check_all(input string tag);
    int w;
    w = model_win();
    chk({tag, ".ready"}, 64'(req_ready), w < 0 ? 64'd0 : 64'd1 << w);
    chk({tag, ".valid"}, 64'(out_valid), 64'(m_v));
    chk({tag, ".rd"}, 64'(out_rd), 64'(m_rd));
    chk({tag, ".wdata"}, out_wdata, m_wd);
    chk({tag, ".pc"}, 64'(out_pc), 64'(m_pc));
    chk({tag, ".wen"}, 64'(out_wen), 64'(m_wen));
    chk({tag, ".src"}, 64'(out_src), 64'(m_src));
    chk({tag, ".cnt"}, 64'(out_retire_cnt), 64'(m_cnt));
  endtask
  // called at a negedge with inputs set: check, clock once, advance the model, return at next negedge
  task automatic tick(input string tag);
    int w;
    #1 check_all(tag);
    w = model_win();
    @(posedge clock);
    if (!reset) model_reset();
    else begin
      if (m_v && out_ready) m_cnt++;
      if (w >= 0) begin
        m_v = 1; m_rd = req_rd[w*5 +: 5]; m_wd = req_wdata[w*64 +: 64]; m_pc = req_pc[w*32 +: 32];
        m_wen = m_rd != 0; m_src = w;
        if (RR) m_p = (w + 1) % N;
      end else if (out_ready) m_v = 0;
    end
    @(negedge clock);
  endtask
  initial begin
    reset = 0; req_valid = '1; out_ready = 1; rnd_payload(); model_reset();
    @(negedge clock);
    tick("rst");
    chk("rst_ready", 64'(req_ready), 64'd0);
    reset = 1;
    ord = RR ? '{0, 1, 2, 0} : '{0, 0, 0, 0};
    for (int k = 0; k < 4; k++) begin
      req_valid = '1; rnd_payload();
      tick("order");
      chk("order_src", 64'(out_src), 64'(ord[k]));
    end
    req_valid = 3'b010; rnd_payload();
    req_rd[9:5] = 5'd5; req_wdata[127:64] = 64'hDEADBEEF;
    tick("lsu");
    chk("lsu_ready", 64'(req_ready), 64'b010);
    chk("lsu_rd", 64'(out_rd), 64'd5);
    chk("lsu_wen", 64'(out_wen), 64'd1);
    chk("lsu_src", 64'(out_src), 64'd1);
    chk("lsu_wdata", out_wdata, 64'hDEADBEEF);
    out_ready = 0; req_valid = '1;
    tick("fill");
    s_cnt = out_retire_cnt; s_rd = out_rd; s_wd = out_wdata;
    for (int k = 0; k < 4; k++) begin
      rnd_payload();
      tick("stall");
      chk("stall_ready", 64'(req_ready), 64'd0);
      chk("stall_rd", 64'(out_rd), 64'(s_rd));
      chk("stall_wd", out_wdata, s_wd);
      chk("stall_cnt", 64'(out_retire_cnt), 64'(s_cnt));
    end
    out_ready = 1; req_valid = 3'b001; rnd_payload();
    tick("refill");
    chk("refill_src", 64'(out_src), 64'd0);
    chk("refill_cnt", 64'(out_retire_cnt), 64'(s_cnt + 1));
    req_valid = 3'b001; rnd_payload(); req_rd[4:0] = 5'd0; req_wdata[63:0] = 64'h1234;
    tick("rd0");
    s_cnt = out_retire_cnt;
    chk("rd0_valid", 64'(out_valid), 64'd1);
    chk("rd0_wen", 64'(out_wen), 64'd0);
    chk("rd0_wdata", out_wdata, 64'h1234);
    req_valid = '0;
    tick("drain");
    chk("drain_cnt", 64'(out_retire_cnt), 64'(s_cnt + 1));
    chk("drain_valid", 64'(out_valid), 64'd0);
    for (int k = 0; k < 300; k++) begin
      req_valid = 3'($urandom); out_ready = $urandom_range(0, 3) != 0; rnd_payload();
      tick("rand");
    end
    req_valid = '1; out_ready = 0; rnd_payload();
    tick("pre_arst");
    chk("pre_arst_valid", 64'(out_valid), 64'd1);
    #2 reset = 0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_cnt", 64'(out_retire_cnt), 64'd0);
    chk("arst_ready", 64'(req_ready), 64'd0);
    model_reset();
    @(negedge clock);
    tick("arst_hold");
    reset = 1;
    for (int k = 0; k < 100; k++) begin
      req_valid = 3'($urandom); out_ready = $urandom_range(0, 3) != 0; rnd_payload();
      tick("rand2");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ysyx_wb_arb.md
YSYX_WB_ARB -- requirements
Module: ysyx_wb_arb

Interface
REQ-001 SHALL have parameter XLEN, default `YSYX_XLEN, datapath width.
REQ-002 SHALL have parameter NREQ, default 3, requester count (0=ALU, 1=LSU, 2=SYS/CSR).
REQ-003 SHALL have port clock  input  1  single clock for all state.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester writeback request.
REQ-006 SHALL have port req_ready  output  NREQ  per-requester accept; one-hot or zero.
REQ-007 SHALL have port req_rd  input  NREQ*5  destination register, slice i = requester i.
REQ-008 SHALL have port req_wdata  input  NREQ*XLEN  writeback data.
REQ-009 SHALL have port req_pc  input  NREQ*32  retiring instruction PC.
REQ-010 SHALL have port out_valid  output  1  registered writeback slot occupied.
REQ-011 SHALL have port out_ready  input  1  downstream (WBU/regfile) accepts slot.
REQ-012 SHALL have port out_rd / out_wdata / out_pc  output  5 / XLEN / 32  registered payload.
REQ-013 SHALL have port out_wen  output  1  regfile write enable.
REQ-014 SHALL have port out_src  output  2  index of granted requester.
REQ-015 SHALL have port out_retire_cnt  output  32  retired-slot counter.

Function
REQ-016 Requester transfer SHALL occur when req_valid[i] and req_ready[i] are both high on a rising edge.
REQ-017 Output slot SHALL be free when out_valid=0 or out_ready=1 (same-cycle drain and refill allowed).
REQ-018 req_ready SHALL be combinational: one-hot of the arbitration winner when slot free, else all zero.
REQ-019 Arbitration SHALL consider only requesters with req_valid high; no valid requester means req_ready=0.
REQ-020 On transfer, payload SHALL register into out_* and out_valid SHALL go high next cycle; latency exactly 1 cycle.
REQ-021 Slot full and out_ready=0: out_* and out_valid SHALL hold stable; req_ready all zero.
REQ-022 Slot drained with no transfer: out_valid SHALL go 0 next cycle.
REQ-023 out_wen SHALL equal 1 only when captured rd != 0; rd=0 SHALL capture with out_wen=0.
REQ-024 out_retire_cnt SHALL increment by 1 per cycle with out_valid and out_ready both high; wraps 0xFFFFFFFF -> 0.
REQ-025 Requester payload SHALL be sampled only at its own transfer edge; later input changes SHALL not affect out_*.
REQ-026 Requester i not granted SHALL not be starved longer than NREQ-1 transfers when round-robin is enabled.

Reset
REQ-027 Reset low SHALL immediately clear out_valid, out_wen, out_src, out_retire_cnt and priority pointer to 0, independent of clock.
REQ-028 out_rd, out_wdata, out_pc SHALL reset to 0.
REQ-029 Reset asserted mid-transfer SHALL discard the in-flight slot; no req_ready high while reset low.
REQ-030 First transfer after reset release SHALL occur no earlier than the first rising edge with reset high.

Configuration
REQ-031 Macro YSYX_WB_ARB_RR_EN defined: round-robin; pointer moves to (winner+1) mod NREQ after each transfer; search starts at pointer.
REQ-032 Macro YSYX_WB_ARB_RR_EN undefined: fixed priority, lowest index wins; no pointer register.

Verification
REQ-033 Reset low, all valid high -> req_ready=000, out_valid=0, out_retire_cnt=0.
REQ-034 Only LSU valid, rd=5, wdata=0xDEADBEEF, out_ready=1 -> req_ready=010; next cycle out_valid=1, out_rd=5, out_wen=1, out_src=1.
REQ-035 All three valid continuously, out_ready=1, RR_EN defined -> grant order 0,1,2,0; undefined -> 0,0,0,0.
REQ-036 Slot full, out_ready=0 for 4 cycles -> out_* stable, req_ready=000, counter unchanged; out_ready=1 with ALU valid -> same-edge refill, counter +1.
REQ-037 ALU request rd=0, wdata=0x1234 -> out_valid=1, out_wen=0, counter +1 on drain.
REQ-038 Counter preloaded near 0xFFFFFFFF by 2 drains -> reads 0x00000001; reset low mid-slot -> out_valid=0 asynchronously.
